// File: rtl/coef_fetch_seq_if.sv
// Weight stream between coef_fetch_seq and the BWN MAC array.
// The master presents 16-bit beats with a last-beat tag, and the slave throttles them with m_ready.
interface coef_fetch_seq_if;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/coef_fetch_seq.sv
// Streams a run of coefficients from a combinational ROM through a 2-entry buffer onto a valid/ready stream.
// Define COEF_BINARIZE_EN to emit sign-binarized weights (+1/-1) instead of raw coefficients.
module coef_fetch_seq #(
  parameter int WIDTH_A = 12,
  parameter int DEPTH   = 80
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH_A-1:0] base_addr,
  input  logic [WIDTH_A-1:0] len,
  output logic               busy,
  output logic [WIDTH_A-1:0] rom_addr,
  input  logic [15:0]        rom_coef,
  output logic               done,
  output logic               err,
  coef_fetch_seq_if.master   m
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam logic [WIDTH_A:0] DEPTH_W = (WIDTH_A+1)'(DEPTH);

  state_t             state;
  logic [WIDTH_A-1:0] remaining;
  logic [15:0]        fifo_data [2];
  logic               fifo_last [2];
  logic               head;
  logic [1:0]         count;

  logic               pop;
  logic               push;
  logic               tail;
  logic               over_range;
  logic [15:0]        push_data;

  assign pop        = m.m_valid && m.m_ready;
  assign push       = (state == FETCH) && ((count != 2'd2) || pop);
  // With two slots, the tail is the head when empty or full and the other slot otherwise.
  assign tail       = head ^ count[0];
  assign over_range = ({1'b0, base_addr} + {1'b0, len}) > DEPTH_W;

`ifdef COEF_BINARIZE_EN
  assign push_data = rom_coef[15] ? 16'hFFFF : 16'h0001;
`else
  assign push_data = rom_coef;
`endif

  assign m.m_valid = (count != 2'd0);
  assign m.m_data  = fifo_data[head];
  assign m.m_last  = fifo_last[head];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      remaining    <= '0;
      rom_addr     <= '0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
      head         <= 1'b0;
      count        <= 2'd0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      if (pop) begin
        head <= ~head;
      end

      if (push) begin
        fifo_data[tail] <= push_data;
        fifo_last[tail] <= (remaining == WIDTH_A'(1));
        rom_addr        <= rom_addr + WIDTH_A'(1);
        remaining       <= remaining - WIDTH_A'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else if (over_range) begin
              err <= 1'b1;
            end else begin
              rom_addr  <= base_addr;
              remaining <= len;
              state     <= FETCH;
            end
          end
        end
        FETCH: begin
          if (push && (remaining == WIDTH_A'(1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The last-tagged entry can only reach the head after the final push, so it is always popped here.
          if (pop && fifo_last[head]) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coef_fetch_seq.sv
// Directed bench for coef_fetch_seq, with a behavioural coefficient ROM and hand-computed beat sequences.
module tb_coef_fetch_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] base_addr;
  logic [11:0] len;
  logic        busy;
  logic [11:0] rom_addr;
  logic [15:0] rom_coef;
  logic        done;
  logic        err;

  coef_fetch_seq_if mif ();

  coef_fetch_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .rom_addr  (rom_addr),
    .rom_coef  (rom_coef),
    .done      (done),
    .err       (err),
    .m         (mif)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] beatData [16];
  logic        beatLast [16];
  int          beatCount;
  logic        sawDone;
  logic        sawErr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] romVal(input int a);
    case (a)
      0:       return 16'hFE0D;
      1:       return 16'h000F;
      2:       return 16'hFF71;
      79:      return 16'hFEBA;
      default: return 16'(a * 37);
    endcase
  endfunction

  // Expected beat value for a ROM address, in whichever build is being simulated.
  function automatic logic [15:0] expCoef(input int a);
    logic [15:0] raw;
    raw = romVal(a);
`ifdef COEF_BINARIZE_EN
    return raw[15] ? 16'hFFFF : 16'h0001;
`else
    return raw;
`endif
  endfunction

  assign rom_coef = romVal(int'(rom_addr));

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] b, input logic [11:0] l);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Records every handshake until done, within a cycle budget.
  task automatic collectBeats(input int budget);
    beatCount = 0;
    sawDone   = 1'b0;
    sawErr    = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (err) sawErr = 1'b1;
      if (done) begin
        sawDone = 1'b1;
        break;
      end
      if (mif.m_valid && mif.m_ready && beatCount < 16) begin
        beatData[beatCount] = mif.m_data;
        beatLast[beatCount] = mif.m_last;
        beatCount++;
      end
      tick();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    len         = '0;
    mif.m_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_busy",   busy,         0);
    checkOutput("rst_addr",   rom_addr,     0);
    checkOutput("rst_valid",  mif.m_valid,  0);
    checkOutput("rst_data",   mif.m_data,   0);
    checkOutput("rst_last",   mif.m_last,   0);
    checkOutput("rst_done",   done,         0);
    checkOutput("rst_err",    err,          0);
    rst_n = 1'b1;
    tick();

    $display("[TB] run base=0 len=3, m_ready high");
    mif.m_ready = 1'b1;
    applyStimulus(12'd0, 12'd3);
    checkOutput("r1_busy_k",  busy,        1);
    checkOutput("r1_addr_k",  rom_addr,    0);
    checkOutput("r1_valid_k", mif.m_valid, 0);
    tick();
    checkOutput("r1_b0_valid", mif.m_valid, 1);
    checkOutput("r1_b0_data",  mif.m_data,  expCoef(0));
    checkOutput("r1_b0_last",  mif.m_last,  0);
    tick();
    checkOutput("r1_b1_valid", mif.m_valid, 1);
    checkOutput("r1_b1_data",  mif.m_data,  expCoef(1));
    checkOutput("r1_b1_last",  mif.m_last,  0);
    tick();
    checkOutput("r1_b2_valid", mif.m_valid, 1);
    checkOutput("r1_b2_data",  mif.m_data,  expCoef(2));
    checkOutput("r1_b2_last",  mif.m_last,  1);
    checkOutput("r1_b2_done",  done,        0);
    tick();
    checkOutput("r1_done",     done,        1);
    checkOutput("r1_busy_end", busy,        0);
    checkOutput("r1_valid_end", mif.m_valid, 0);
    tick();
    checkOutput("r1_done_once", done,       0);

    $display("[TB] run base=0 len=3 with 4-cycle downstream stall");
    mif.m_ready = 1'b0;
    applyStimulus(12'd0, 12'd3);
    tick();
    checkOutput("r2_first_valid", mif.m_valid, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("r2_hold_valid", mif.m_valid, 1);
      checkOutput("r2_hold_data",  mif.m_data,  expCoef(0));
      checkOutput("r2_hold_last",  mif.m_last,  0);
      checkOutput("r2_hold_addr",  rom_addr,    2);
    end
    mif.m_ready = 1'b1;
    collectBeats(20);
    checkOutput("r2_count", beatCount, 3);
    for (int i = 0; i < 3 && i < beatCount; i++) begin
      checkOutput("r2_data", beatData[i], expCoef(i));
      checkOutput("r2_last", beatLast[i], (i == 2) ? 1 : 0);
    end
    checkOutput("r2_done", sawDone, 1);
    tick();

    $display("[TB] run base=79 len=1 at top of ROM");
    applyStimulus(12'd79, 12'd1);
    tick();
    checkOutput("r3_valid", mif.m_valid, 1);
    checkOutput("r3_data",  mif.m_data,  expCoef(79));
    checkOutput("r3_last",  mif.m_last,  1);
    tick();
    checkOutput("r3_done",  done,        1);
    checkOutput("r3_valid_end", mif.m_valid, 0);
    tick();

    $display("[TB] out-of-range run base=79 len=2");
    applyStimulus(12'd79, 12'd2);
    checkOutput("r4_err",   err,         1);
    checkOutput("r4_busy",  busy,        0);
    checkOutput("r4_valid", mif.m_valid, 0);
    checkOutput("r4_done",  done,        0);
    tick();
    checkOutput("r4_err_once", err,      0);
    checkOutput("r4_valid2", mif.m_valid, 0);
    checkOutput("r4_busy2",  busy,       0);

    $display("[TB] zero-length run");
    applyStimulus(12'd5, 12'd0);
    checkOutput("r5_done",  done,        1);
    checkOutput("r5_busy",  busy,        0);
    checkOutput("r5_valid", mif.m_valid, 0);
    checkOutput("r5_err",   err,         0);
    tick();
    checkOutput("r5_done_once", done,    0);
    checkOutput("r5_valid2", mif.m_valid, 0);

    $display("[TB] start while busy is ignored");
    applyStimulus(12'd0, 12'd3);
    base_addr = 12'd79;
    len       = 12'd2;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    checkOutput("r6_err_ign", err, 0);
    collectBeats(20);
    checkOutput("r6_count", beatCount, 3);
    for (int i = 0; i < 3 && i < beatCount; i++) begin
      checkOutput("r6_data", beatData[i], expCoef(i));
      checkOutput("r6_last", beatLast[i], (i == 2) ? 1 : 0);
    end
    checkOutput("r6_done", sawDone, 1);
    checkOutput("r6_err",  sawErr,  0);
    tick();

    $display("[TB] reset in the middle of a run, then restart");
    applyStimulus(12'd0, 12'd3);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("r7_busy",  busy,        0);
    checkOutput("r7_addr",  rom_addr,    0);
    checkOutput("r7_valid", mif.m_valid, 0);
    checkOutput("r7_data",  mif.m_data,  0);
    checkOutput("r7_last",  mif.m_last,  0);
    checkOutput("r7_done",  done,        0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("r7_no_done", done,       0);
    checkOutput("r7_valid2",  mif.m_valid, 0);
    applyStimulus(12'd1, 12'd1);
    collectBeats(20);
    checkOutput("r7_count", beatCount, 1);
    if (beatCount >= 1) begin
      checkOutput("r7_beat_data", beatData[0], expCoef(1));
      checkOutput("r7_beat_last", beatLast[0], 1);
    end
    checkOutput("r7_restart_done", sawDone, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
